// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC request arbiter: default data width,
// Q2.14 fraction-bit count and the arbiter FSM state type.
package cordic_pkg;

  localparam int CORDIC_DATA_W    = 16;
  localparam int CORDIC_FRAC_BITS = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/cordic_arbiter_if.sv
// Bundle of the request, core and response signals of cordic_arbiter.
// slave: the arbiter's view. master: the requesters/core/consumer side.
interface cordic_arbiter_if
  import cordic_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = CORDIC_DATA_W
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_angle;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      core_start;
  logic [DATA_W-1:0]         core_angle;
  logic                      core_done;
  logic [DATA_W-1:0]         core_cos;
  logic [DATA_W-1:0]         core_sin;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_cos;
  logic [DATA_W-1:0]         rsp_sin;
  logic                      rsp_err;
  logic                      busy;

  modport slave (
    input  req_valid, req_angle, core_done, core_cos, core_sin, rsp_ready,
    output req_ready, core_start, core_angle, rsp_valid, rsp_id, rsp_cos,
           rsp_sin, rsp_err, busy
  );

  modport master (
    output req_valid, req_angle, core_done, core_cos, core_sin, rsp_ready,
    input  req_ready, core_start, core_angle, rsp_valid, rsp_id, rsp_cos,
           rsp_sin, rsp_err, busy
  );

endinterface

// File: rtl/cordic_rr_arb.sv
// Round-robin winner selection: the search starts at index ptr and wraps
// modulo NUM_REQ; the first set request found is granted (one-hot).
module cordic_rr_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);
  localparam int PTR_W = $clog2(NUM_REQ);

  // rot_req[k] is the request k places after ptr; rot_idx[k] is its real index
  logic [NUM_REQ-1:0] rot_req;
  logic [PTR_W-1:0]   rot_idx [NUM_REQ];
  logic               found;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [PTR_W:0] sum;
      assign sum = {1'b0, ptr} + (PTR_W+1)'(gi);
      assign rot_idx[gi] = (sum >= (PTR_W+1)'(NUM_REQ)) ?
                           PTR_W'(sum - (PTR_W+1)'(NUM_REQ)) : sum[PTR_W-1:0];
      assign rot_req[gi] = req[rot_idx[gi]];
    end
  endgenerate

  // Grant the first requester at or after ptr in rotated order
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot_req[k]) begin
        grant[rot_idx[k]] = 1'b1;
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cordic_arbiter.sv
// Shares one cordic_sin_cos core among NUM_REQ requesters, one request
// outstanding at a time, with round-robin fairness.
// Optional feature macro: CORDIC_ARB_TIMEOUT_EN (abort WAIT after
// TIMEOUT_CYC cycles without core_done and return an error response).
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = CORDIC_DATA_W,
  parameter int TIMEOUT_CYC = 64
) (
  input logic             clk,
  input logic             reset,
  cordic_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t          state_reg, state_next;
  logic [ID_W-1:0]     ptr_reg, ptr_next;
  logic [ID_W-1:0]     id_reg;
  logic [DATA_W-1:0]   angle_reg, cos_reg, sin_reg;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                accept, capture_done;

  cordic_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr_reg),
    .grant (grant)
  );

  // Encode the one-hot grant into the winner index
  always_comb begin
    grant_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_id = ID_W'(i);
    end
  end

  assign ptr_next = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + 1'b1;

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC+1);
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic             tmo_hit, capture_tmo, err_reg;

  assign tmo_hit = (tmo_cnt_reg == TMO_W'(TIMEOUT_CYC-1));

  // Count cycles spent in WAIT; cleared whenever the FSM is elsewhere
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  tmo_cnt_reg <= '0;
    else if (state_reg == WAIT) tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    else                        tmo_cnt_reg <= '0;
  end
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_next     = state_reg;
    accept         = 1'b0;
    capture_done   = 1'b0;
`ifdef CORDIC_ARB_TIMEOUT_EN
    capture_tmo    = 1'b0;
`endif
    bus.req_ready  = '0;
    bus.core_start = 1'b0;
    bus.rsp_valid  = 1'b0;
    bus.busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE: begin
        // req_ready is gated by reset so it reads zero while reset is held
        if (!reset) bus.req_ready = grant;
        if (|bus.req_valid) begin
          accept     = 1'b1;
          state_next = START;
        end
      end
      START: begin
        bus.core_start = 1'b1;
        state_next     = WAIT;
      end
      WAIT: begin
        if (bus.core_done) begin
          capture_done = 1'b1;
          state_next   = RESP;
        end
`ifdef CORDIC_ARB_TIMEOUT_EN
        else if (tmo_hit) begin
          capture_tmo = 1'b1;
          state_next  = RESP;
        end
`endif
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request and result capture registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg   <= '0;
      id_reg    <= '0;
      angle_reg <= '0;
      cos_reg   <= '0;
      sin_reg   <= '0;
`ifdef CORDIC_ARB_TIMEOUT_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      if (accept) begin
        ptr_reg   <= ptr_next;
        id_reg    <= grant_id;
        angle_reg <= bus.req_angle[grant_id*DATA_W +: DATA_W];
      end
      if (capture_done) begin
        cos_reg <= bus.core_cos;
        sin_reg <= bus.core_sin;
`ifdef CORDIC_ARB_TIMEOUT_EN
        err_reg <= 1'b0;
`endif
      end
`ifdef CORDIC_ARB_TIMEOUT_EN
      if (capture_tmo) begin
        cos_reg <= '0;
        sin_reg <= '0;
        err_reg <= 1'b1;
      end
`endif
    end
  end

  assign bus.core_angle = angle_reg;
  assign bus.rsp_id     = id_reg;
  assign bus.rsp_cos    = cos_reg;
  assign bus.rsp_sin    = sin_reg;
`ifdef CORDIC_ARB_TIMEOUT_EN
  assign bus.rsp_err    = err_reg;
`else
  assign bus.rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Self-checking bench for cordic_arbiter. A transaction-level model plus a
// core stub are advanced once per cycle inside step(); DUT outputs are
// compared against the model at every falling edge.
// Stub core result: cos = angle ^ 16'h5A5A, sin = angle + 16'h0101.
module tb_cordic_arbiter;
  localparam int N   = 4;
  localparam int W   = 16;
  localparam int TMO = 64;

  logic clk;
  logic rst;

  cordic_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  cordic_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TMO)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_pass;

  // model of the outstanding transaction
  bit           m_busy, m_resp, m_err;
  int           m_age, m_wait, m_ptr, m_id;
  logic [W-1:0] m_angle, m_cos, m_sin;

  // core stub and monitors
  int           core_lat, stub_cnt, starts;
  logic [W-1:0] stub_angle;
  int           grants[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int rr_pick(logic [N-1:0] v, int p);
    for (int off = 0; off < N; off++) begin
      if (v[(p + off) % N]) return (p + off) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_resp = 0; m_err = 0; m_age = 0; m_wait = 0;
    m_ptr = 0; m_id = 0; m_angle = '0; m_cos = '0; m_sin = '0;
  endtask

  // One clock cycle: compare at negedge, advance stub and model, return at posedge+1
  task automatic step();
    logic [N-1:0] exp_ready;
    int w;
    @(negedge clk);
    if (rst) model_reset();
    w = rr_pick(bus.req_valid, m_ptr);
    exp_ready = '0;
    if (!rst && !m_busy && w >= 0) exp_ready[w] = 1'b1;
    chk("req_ready",  32'(bus.req_ready),  32'(exp_ready));
    chk("busy",       32'(bus.busy),       32'(m_busy));
    chk("core_start", 32'(bus.core_start), 32'(m_busy && m_age == 1));
    chk("core_angle", 32'(bus.core_angle), 32'(m_angle));
    chk("rsp_valid",  32'(bus.rsp_valid),  32'(m_resp));
    if (m_resp) begin
      chk("rsp_id",  32'(bus.rsp_id),  32'(m_id));
      chk("rsp_cos", 32'(bus.rsp_cos), 32'(m_cos));
      chk("rsp_sin", 32'(bus.rsp_sin), 32'(m_sin));
      chk("rsp_err", 32'(bus.rsp_err), 32'(m_err));
    end
    if (!rst) begin
      for (int i = 0; i < N; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) grants.push_back(i);
      if (bus.core_start) starts++;
      if (bus.rsp_valid && bus.rsp_ready)
        $display("rsp id=%0d cos=%h sin=%h err=%0d t=%0t",
                 bus.rsp_id, bus.rsp_cos, bus.rsp_sin, bus.rsp_err, $time);
    end
    // core stub: clears done on start, raises it core_lat cycles later
    if (rst) begin
      bus.core_done = 1'b0;
      stub_cnt = -1;
    end else if (bus.core_start) begin
      bus.core_done = 1'b0;
      stub_angle = bus.core_angle;
      stub_cnt = core_lat;
    end else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        bus.core_done = 1'b1;
        bus.core_cos  = stub_angle ^ 16'h5A5A;
        bus.core_sin  = stub_angle + 16'h0101;
      end
    end
    // model: what the coming clock edge does to the transaction
    if (!rst) begin
      if (!m_busy) begin
        if (w >= 0) begin
          m_busy = 1; m_resp = 0; m_age = 1; m_id = w;
          m_angle = bus.req_angle[w*W +: W];
          m_ptr = (w + 1) % N;
        end
      end else if (m_age == 1) begin
        m_age = 2; m_wait = 0;
      end else if (!m_resp) begin
        if (bus.core_done) begin
          m_resp = 1; m_err = 0; m_cos = bus.core_cos; m_sin = bus.core_sin;
        end
`ifdef CORDIC_ARB_TIMEOUT_EN
        else begin
          m_wait++;
          if (m_wait == TMO) begin
            m_resp = 1; m_err = 1; m_cos = '0; m_sin = '0;
          end
        end
`endif
      end else if (bus.rsp_ready) begin
        m_busy = 0; m_resp = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Raise the masked requests; each drops after its own accept
  task automatic serve(logic [N-1:0] mask, int budget);
    logic [N-1:0] acc;
    int k;
    bus.req_valid = bus.req_valid | mask;
    #1;
    k = 0;
    while ((bus.req_valid & mask) != 0 && k < budget) begin
      acc = bus.req_valid & bus.req_ready;
      step();
      bus.req_valid = bus.req_valid & ~acc;
      #1;
      k++;
    end
    if ((bus.req_valid & mask) != 0) begin
      chk("serve_budget", 32'(bus.req_valid & mask), 32'd0);
      bus.req_valid = '0;
    end
  endtask

  task automatic wait_rsp(int budget);
    int k = 0;
    while (!bus.rsp_valid && k < budget) begin step(); k++; end
    chk("rsp_seen", 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while (bus.busy && k < budget) begin step(); k++; end
    chk("idle", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int base, k, held, s0;
    int exp_seq[5];
    n_checks = 0; n_pass = 0; starts = 0; stub_cnt = -1; core_lat = 3;
    model_reset();
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_angle = '0;
    bus.rsp_ready = 1'b1;
    bus.core_done = 1'b0;
    bus.core_cos  = '0;
    bus.core_sin  = '0;

    // reset state, with every requester asking
    bus.req_valid = '1;
    repeat (3) step();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    bus.req_valid = '0;
    rst = 1'b0;
    step();

    // all four requesting continuously from ptr=0
    for (int i = 0; i < N; i++) bus.req_angle[i*W +: W] = 16'(1000 * (i + 1));
    base = grants.size();
    bus.req_valid = '1;
    k = 0;
    while (grants.size() - base < 5 && k < 200) begin step(); k++; end
    bus.req_valid = '0;
    wait_idle(50);
    exp_seq = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++)
      chk($sformatf("rr_order_%0d", i),
          32'((base + i < grants.size()) ? grants[base + i] : -1), 32'(exp_seq[i]));

    // single request: requester 0, angle 12867
    bus.req_angle[0 +: W] = 16'd12867;
    s0 = starts;
    serve(4'b0001, 20);
    chk("single_start", 32'(bus.core_start), 32'd1);
    chk("single_angle", 32'(bus.core_angle), 32'd12867);
    wait_rsp(50);
    chk("single_id",  32'(bus.rsp_id),  32'd0);
    chk("single_cos", 32'(bus.rsp_cos), 32'h6819);
    chk("single_sin", 32'(bus.rsp_sin), 32'h3344);
    chk("single_err", 32'(bus.rsp_err), 32'd0);
    wait_idle(20);
    chk("single_start_count", 32'(starts - s0), 32'd1);

    // backpressure on requester 3's response while requester 0 waits
    bus.rsp_ready = 1'b0;
    bus.req_angle[3*W +: W] = 16'h0100;
    serve(4'b1000, 20);
    wait_rsp(50);
    bus.req_valid[0] = 1'b1;
    #1;
    held = 0;
    repeat (10) begin
      if (bus.rsp_valid && bus.rsp_id == 2'd3 && bus.rsp_cos == 16'h5B5A &&
          bus.rsp_sin == 16'h0201 && bus.req_ready == '0) held++;
      step();
    end
    chk("bp_hold_cycles", 32'(held), 32'd10);
    bus.rsp_ready = 1'b1;
    serve(4'b0001, 20);
    wait_idle(50);

    // move ptr to 2, then requesters 1 and 3 together
    serve(4'b0010, 20);
    wait_idle(50);
    base = grants.size();
    serve(4'b1010, 100);
    wait_idle(50);
    chk("rr_ptr2_first",  32'((base < grants.size()) ? grants[base] : -1), 32'd3);
    chk("rr_ptr2_second", 32'((base + 1 < grants.size()) ? grants[base + 1] : -1), 32'd1);

    // reset asserted in WAIT aborts the transaction
    core_lat = 20;
    serve(4'b0001, 20);
    step();
    chk("abort_in_wait", 32'({bus.busy, bus.core_start}), 32'b10);
    #1;
    rst = 1'b1;
    bus.req_valid = 4'b0100;
    #1;
    chk("abort_busy",      32'(bus.busy),       32'd0);
    chk("abort_req_ready", 32'(bus.req_ready),  32'd0);
    chk("abort_start",     32'(bus.core_start), 32'd0);
    chk("abort_angle",     32'(bus.core_angle), 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid),  32'd0);
    chk("abort_rsp_id",    32'(bus.rsp_id),     32'd0);
    chk("abort_rsp_cos",   32'(bus.rsp_cos),    32'd0);
    chk("abort_rsp_sin",   32'(bus.rsp_sin),    32'd0);
    chk("abort_rsp_err",   32'(bus.rsp_err),    32'd0);
    step();
    bus.req_valid = '0;
    rst = 1'b0;
    held = 0;
    repeat (25) begin
      if (bus.rsp_valid) held++;
      step();
    end
    chk("abort_no_rsp", 32'(held), 32'd0);
    core_lat = 3;
    bus.req_angle[2*W +: W] = 16'h1234;
    serve(4'b0100, 20);
    wait_rsp(50);
    chk("after_abort_id",  32'(bus.rsp_id),  32'd2);
    chk("after_abort_cos", 32'(bus.rsp_cos), 32'h486E);
    chk("after_abort_sin", 32'(bus.rsp_sin), 32'h1335);
    wait_idle(20);

`ifdef CORDIC_ARB_TIMEOUT_EN
    // core never finishes: error response after 64 WAIT cycles
    core_lat = -1;
    serve(4'b0001, 20);
    k = 0;
    while (!bus.rsp_valid && k < 200) begin step(); k++; end
    chk("tmo_latency", 32'(k), 32'd65);
    chk("tmo_err", 32'(bus.rsp_err), 32'd1);
    chk("tmo_cos", 32'(bus.rsp_cos), 32'd0);
    chk("tmo_sin", 32'(bus.rsp_sin), 32'd0);
    wait_idle(20);
`endif

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one cordic_sin_cos core (2..8).
REQ-002 Parameter DATA_W, 16, width of angle (signed Q2.14 radians) and of cos/sin results.
REQ-003 Parameter TIMEOUT_CYC, 64, WAIT-state cycle limit, used only with CORDIC_ARB_TIMEOUT_EN.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 reset  in  1  asynchronous active-high reset.
REQ-007 req_valid  in  NUM_REQ  per-requester request.
REQ-008 req_angle  in  NUM_REQ*DATA_W  per-requester angle; slice i belongs to requester i.
REQ-009 req_ready  out  NUM_REQ  one-hot accept pulse; request accepted when req_valid[i] & req_ready[i].
REQ-010 core_start  out  1  single-cycle start pulse to the core.
REQ-011 core_angle  out  DATA_W  angle to the core, held stable from START until the next accept.
REQ-012 core_done  in  1  core completion level.
REQ-013 core_cos, core_sin  in  DATA_W each  core results, valid while core_done=1.
REQ-014 rsp_valid  out  1  response available.
REQ-015 rsp_ready  in  1  response consumer ready.
REQ-016 rsp_id  out  clog2(NUM_REQ)  index of requester the response belongs to.
REQ-017 rsp_cos, rsp_sin  out  DATA_W each  latched results.
REQ-018 rsp_err  out  1  response is a timeout error.
REQ-019 busy  out  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, START, WAIT, RESP.
REQ-021 IDLE: if any req_valid, assert req_ready for the round-robin winner that cycle, latch its angle and id, go to START; otherwise stay.
REQ-022 Round-robin: search starts at pointer ptr; after each accept ptr = winner+1 modulo NUM_REQ; a lone requester is granted every time.
REQ-023 START: core_start=1 for exactly one cycle, then go to WAIT.
REQ-024 WAIT: on the first cycle core_done=1, latch core_cos/core_sin, rsp_err=0, go to RESP; the core clears done on start.
REQ-025 RESP: rsp_valid=1 with rsp_id/rsp_cos/rsp_sin/rsp_err stable until rsp_valid & rsp_ready, then go to IDLE.
REQ-026 Latency: accept at cycle T, core_start at T+1, rsp_valid one cycle after the first sampled core_done.
REQ-027 No new request is accepted in START, WAIT or RESP; req_ready is all-zero there.
REQ-028 rsp_ready high while rsp_valid low SHALL have no effect.

Reset
REQ-029 Reset SHALL force IDLE, ptr=0, req_ready=0, core_start=0, core_angle=0, rsp_valid=0, rsp_id=0, rsp_cos=0, rsp_sin=0, rsp_err=0, busy=0.
REQ-030 Reset asserted mid-operation SHALL abort immediately; no response is produced for the aborted request.

Configuration
REQ-031 With CORDIC_ARB_TIMEOUT_EN defined: a counter runs in WAIT; after TIMEOUT_CYC cycles without core_done, go to RESP with rsp_err=1 and rsp_cos=rsp_sin=0.
REQ-032 Without CORDIC_ARB_TIMEOUT_EN: WAIT lasts indefinitely, no counter exists, rsp_err is constant 0.

Structure
REQ-033 Package cordic_pkg SHALL hold DATA_W default, Q2.14 fraction-bit constant (14), and the FSM state typedef.
REQ-034 Round-robin winner selection SHALL be the sub-module cordic_rr_arb (req vector and ptr in, one-hot grant out).

Verification
REQ-035 Single request: req 0 angle 16'sd12867 -> core_angle=12867, one core_start, rsp_id=0, rsp_cos=rsp_sin=core values.
REQ-036 All four requesting continuously from ptr=0 -> grants in order 0,1,2,3,0, one outstanding at a time.
REQ-037 Backpressure: rsp_ready=0 for 10 cycles -> rsp_valid and data held, no new req_ready until handshake.
REQ-038 Reset asserted in WAIT -> all outputs at reset values the next sample; later req 2 served normally with rsp_id=2.
REQ-039 CORDIC_ARB_TIMEOUT_EN, core_done never rises -> rsp_valid with rsp_err=1 after 64 WAIT cycles, results 0.
REQ-040 Requesters 1 and 3 valid in the same cycle with ptr=2 -> requester 3 granted first, then 1.
